// File: rtl/tl_arbiter_ctrl.sv
// tl_arbiter_ctrl: sequences RESET/INIT/IDLE/ACTIVE, latches thresholds, arbitrates input FIFO pops into class-routed output pushes
module tl_arbiter_ctrl #(
  parameter int DW = 12,
  parameter int CLASS_LSB = 8,
  parameter int TW = 3,
  parameter int RR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [TW-1:0]   umbral_bajo_in,
  input  logic [TW-1:0]   umbral_alto_in,
  input  logic [3:0]      in_empty,
  input  logic [4*DW-1:0] in_data,
  input  logic [3:0]      out_almost_full,
  output logic [3:0]      in_pop,
  output logic [3:0]      out_push,
  output logic [DW-1:0]   out_data,
  output logic [TW-1:0]   umbral_bajo,
  output logic [TW-1:0]   umbral_alto,
  output logic [1:0]      state,
  output logic            idle
);
  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;
  state_t st, st_nxt;
  logic [1:0] ptr, start, idx, gidx, cls;
  logic [3:0] elig;
  logic gnt;
  logic [DW-1:0] word;
  always_comb begin
    for (int i = 0; i < 4; i++)
      elig[i] = !in_empty[i] && !out_almost_full[in_data[i*DW+CLASS_LSB +: 2]];
  end
  // Scan from start+4 down to start+1 so the first eligible index after start wins
  always_comb begin
    start = (RR != 0) ? ptr : 2'd3;
    gnt = 1'b0;
    gidx = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = start + 2'(k);
      if (elig[idx]) begin
        gnt = 1'b1;
        gidx = idx;
      end
    end
    gnt = gnt && (st == S_IDLE || st == S_ACTIVE) && !init;
    word = in_data[gidx*DW +: DW];
    cls = word[CLASS_LSB +: 2];
    in_pop = gnt ? 4'(1) << gidx : 4'b0;
    st_nxt = (st != S_RESET && init) ? S_INIT :
             (st == S_RESET)         ? (init ? S_INIT : S_IDLE) :
             (st == S_INIT)          ? S_IDLE :
             (gnt ? S_ACTIVE : S_IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_RESET;
      ptr <= 2'd3;
      out_push <= 4'b0;
      out_data <= '0;
      umbral_bajo <= '0;
      umbral_alto <= '0;
    end else begin
      st <= st_nxt;
      out_push <= gnt ? 4'(1) << cls : 4'b0;
      if (gnt) begin
        ptr <= gidx;
        out_data <= word;
      end
      if (st == S_INIT && init) begin
        umbral_bajo <= umbral_bajo_in;
        umbral_alto <= umbral_alto_in;
      end
    end
  end
  assign state = st;
  assign idle = (st == S_IDLE || st == S_INIT) && &in_empty && out_push == 4'b0;
endmodule

// File: tb/tb_tl_arbiter_ctrl.sv
// tb_tl_arbiter_ctrl: directed stimulus with queued expected pushes checked by a negedge monitor
module tb_tl_arbiter_ctrl;
  localparam int DW = 12;
  localparam int TW = 3;
  logic clk = 1'b0;
  logic reset, init, sel;
  logic [TW-1:0] bajo_in, alto_in;
  logic [3:0] in_empty, af;
  logic [4*DW-1:0] in_data;
  logic [3:0] pop0, pop1, push0, push1;
  logic [DW-1:0] od0, od1;
  logic [TW-1:0] ub0, ub1, ua0, ua1;
  logic [1:0] st0, st1;
  logic idle0, idle1;
  logic [3:0] pop_s, push_s, last_pop;
  logic [DW-1:0] od_s;
  logic [TW-1:0] ub_s, ua_s;
  logic [1:0] st_s;
  logic idle_s;
  logic [DW-1:0] q [4][$];
  logic [15:0] expq [$];
  int n_chk = 0, n_fail = 0, push_cnt = 0;

  always #5 clk = ~clk;

  tl_arbiter_ctrl #(.DW(DW), .CLASS_LSB(8), .TW(TW), .RR(0)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_bajo_in(bajo_in), .umbral_alto_in(alto_in),
    .in_empty(in_empty), .in_data(in_data), .out_almost_full(af), .in_pop(pop0), .out_push(push0),
    .out_data(od0), .umbral_bajo(ub0), .umbral_alto(ua0), .state(st0), .idle(idle0));

  tl_arbiter_ctrl #(.DW(DW), .CLASS_LSB(8), .TW(TW), .RR(1)) dut_rr (
    .clk(clk), .reset(reset), .init(init), .umbral_bajo_in(bajo_in), .umbral_alto_in(alto_in),
    .in_empty(in_empty), .in_data(in_data), .out_almost_full(af), .in_pop(pop1), .out_push(push1),
    .out_data(od1), .umbral_bajo(ub1), .umbral_alto(ua1), .state(st1), .idle(idle1));

  assign pop_s  = sel ? pop1 : pop0;
  assign push_s = sel ? push1 : push0;
  assign od_s   = sel ? od1 : od0;
  assign ub_s   = sel ? ub1 : ub0;
  assign ua_s   = sel ? ua1 : ua0;
  assign st_s   = sel ? st1 : st0;
  assign idle_s = sel ? idle1 : idle0;

  always @(negedge clk) begin
    if (reset && push_s != 4'b0) begin
      push_cnt++;
      n_chk++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_push: got push=%b data=%h, expected none", push_s, od_s);
      end else begin
        logic [15:0] e;
        e = expq.pop_front();
        if ({push_s, od_s} != e) begin
          n_fail++;
          $display("FAIL push_word: got push=%b data=%h, expected push=%b data=%h", push_s, od_s, e[15:12], e[11:0]);
        end
      end
    end
    if (reset && pop_s != 4'b0) begin
      n_chk++;
      if ($countones(pop_s) != 1) begin
        n_fail++;
        $display("FAIL pop_onehot: got %b, expected one-hot", pop_s);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = (q[i].size() == 0);
      in_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    last_pop = pop_s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (last_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && expq.size() != 0; n++) step();
    step();
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic do_reset_init();
    reset = 1'b0;
    init = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    refresh();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    init = 1'b0;
    step();
    check("reinit_state", st_s, 2);
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b0;
    init = 1'b1;
    af = 4'b0;
    alto_in = 3'd7;
    bajo_in = 3'd0;
    q[3].push_back(12'h3FF);
    refresh();
    #2;
    check("rst_state", st_s, 0);
    check("rst_push", push_s, 0);
    check("rst_data", od_s, 0);
    check("rst_alto", ua_s, 0);
    check("rst_bajo", ub_s, 0);
    check("rst_idle", idle_s, 0);
    check("rst_pop", pop_s, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("pop_in_reset", last_pop, 0);
    check("init_state", st_s, 1);
    step();
    check("pop_in_init", last_pop, 0);
    alto_in = 3'd6;
    bajo_in = 3'd1;
    step();
    check("pop_in_init2", last_pop, 0);
    init = 1'b0;
    alto_in = 3'd3;
    bajo_in = 3'd3;
    expq.push_back({4'b1000, 12'h3FF});
    step();
    check("pop_init_exit", last_pop, 0);
    check("idle_state", st_s, 2);
    check("thr_alto", ua_s, 6);
    check("thr_bajo", ub_s, 1);
    drain();
    step();
    check("idle_flag", idle_s, 1);

    q[0].push_back(12'h001);
    q[1].push_back(12'h102);
    q[2].push_back(12'h204);
    q[3].push_back(12'h308);
    refresh();
    expq.push_back({4'b0001, 12'h001});
    expq.push_back({4'b0010, 12'h102});
    expq.push_back({4'b0100, 12'h204});
    expq.push_back({4'b1000, 12'h308});
    for (int k = 0; k < 4; k++) begin
      step();
      check("route_pop", last_pop, 1 << k);
    end
    drain();

    for (int j = 0; j < 3; j++) begin
      q[0].push_back(12'(12'h110 + j));
      q[2].push_back(12'(12'h120 + j));
    end
    refresh();
    for (int j = 0; j < 3; j++) expq.push_back({4'b0010, 12'(12'h110 + j)});
    for (int j = 0; j < 3; j++) expq.push_back({4'b0010, 12'(12'h120 + j)});
    for (int k = 0; k < 6; k++) begin
      step();
      check("prio_pop", last_pop, k < 3 ? 1 : 4);
    end
    drain();

    af = 4'b0100;
    q[0].push_back(12'h230);
    q[1].push_back(12'h031);
    refresh();
    expq.push_back({4'b0001, 12'h031});
    step();
    check("bp_pop_fifo1", last_pop, 2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_fifo0", last_pop, 0);
    end
    af = 4'b0000;
    expq.push_back({4'b0100, 12'h230});
    step();
    check("bp_release", last_pop, 1);
    drain();

    sel = 1'b1;
    alto_in = 3'd5;
    bajo_in = 3'd2;
    do_reset_init();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) q[i].push_back(12'(i * 256 + j * 16 + i));
    refresh();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) expq.push_back({4'(1 << i), 12'(i * 256 + j * 16 + i)});
    push_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      check("rr_pop", last_pop, 1 << (k % 4));
    end
    drain();
    check("rr_push_count", push_cnt, 16);
    step();
    check("rr_end_state", st_s, 2);
    check("rr_end_idle", idle_s, 1);

    q[1].push_back(12'h340);
    q[1].push_back(12'h341);
    q[1].push_back(12'h342);
    refresh();
    expq.push_back({4'b1000, 12'h340});
    step();
    check("mid_pop", last_pop, 2);
    init = 1'b1;
    step();
    check("mid_init_nopop", last_pop, 0);
    step();
    check("mid_init_nopop2", last_pop, 0);
    check("mid_init_state", st_s, 1);
    check("mid_init_alto", ua_s, 5);
    init = 1'b0;
    step();
    check("mid_exit_nopop", last_pop, 0);
    step();
    check("mid_resume_pop", last_pop, 2);
    check("mid_push_live", push_s, 4'b1000);
    reset = 1'b0;
    #1;
    check("async_push_clr", push_s, 0);
    check("async_alto_clr", ua_s, 0);
    check("async_bajo_clr", ub_s, 0);
    check("async_state", st_s, 0);
    check("final_pending", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
